// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling FSM, and a
// valid/ack output holding register with framing-error and overrun reporting.
module uart_rx #(
  parameter int BAUD_DIV = 10416,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_END = 16'(BAUD_DIV);
  localparam logic [15:0] HALF_END = 16'(HALF_DIV);

  logic        rx_m;
  logic        rx_s;
  state_t      state;
  state_t      state_next;
  logic [15:0] cnt;
  logic [15:0] cnt_next;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_next;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic        byte_done;
  logic        stop_bad;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // FSM state, baud counter, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
    end
  end

  // Next-state logic; the start bit is confirmed at its midpoint so every
  // later sample lands mid-bit after a whole bit period.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    byte_done    = 1'b0;
    stop_bad     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == BAUD_END) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      STOP: begin
        if (cnt == BAUD_END) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (rx_s) byte_done = 1'b1;
          else      stop_bad  = 1'b1;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Host-side holding register: a completing byte wins over a same-cycle ack,
  // a byte arriving while one is still held is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (byte_done && (!rx_valid || rx_ack)) begin
        data_out <= shift;
        rx_valid <= 1'b1;
      end else if (byte_done) begin
        overrun <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// scored against a frame-level model of the receiver's host interface.
module tb_uart_rx;

  localparam int BAUD     = 15;
  localparam int BIT_CLKS = BAUD + 1;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rx_ack;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int n_vec = 0;
  int n_err = 0;
  int fe_pulses = 0;
  int fe_cycles = 0;
  bit fe_prev = 0;
  bit abort_tx = 0;

  uart_rx #(.BAUD_DIV(BAUD), .HALF_DIV(BAUD / 2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_ack(rx_ack),
    .data_out(data_out), .rx_valid(rx_valid), .busy(busy),
    .frame_err(frame_err), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_err pulses and the total cycles it is high.
  always @(negedge clk) begin
    if (frame_err) fe_cycles <= fe_cycles + 1;
    if (frame_err && !fe_prev) fe_pulses <= fe_pulses + 1;
    fe_prev <= frame_err;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame; stop_ok=0 drives the stop bit low.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int c = 0; c < BIT_CLKS; c++) begin
        @(posedge clk);
        #1;
        if (abort_tx) begin
          rx = 1'b1;
          return;
        end
      end
    end
    rx = 1'b1;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", data_out); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    tick(3);
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_basic();
    int lat;
    int fe0;
    fe0 = fe_pulses;
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!rx_valid && lat < 300) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    n_vec++; if (lat < 152 || lat > 156) begin n_err++; $display("FAIL basic_latency got=%0d exp=152..156", lat); end
    n_vec++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL basic_data got=%h exp=a5", data_out); end
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", rx_valid); end
    n_vec++; if (fe_pulses !== fe0) begin n_err++; $display("FAIL basic_ferr got=%0d exp=%0d", fe_pulses, fe0); end
    pulse_ack();
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL basic_ack got=%b exp=0", rx_valid); end
    tick(5);
  endtask

  task automatic test_frame_err();
    int p0;
    int c0;
    p0 = fe_pulses;
    c0 = fe_cycles;
    send_frame(8'h55, 1'b0);
    tick(30);
    n_vec++; if (fe_pulses !== p0 + 1) begin n_err++; $display("FAIL ferr_pulses got=%0d exp=%0d", fe_pulses, p0 + 1); end
    n_vec++; if (fe_cycles !== c0 + 1) begin n_err++; $display("FAIL ferr_width got=%0d exp=%0d", fe_cycles, c0 + 1); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ferr_valid got=%b exp=0", rx_valid); end
    n_vec++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL ferr_data got=%h exp=a5", data_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy got=%b exp=0", busy); end
  endtask

  task automatic test_glitch();
    bit saw_busy;
    int p0;
    saw_busy = 0;
    p0 = fe_pulses;
    for (int i = 0; i < 30; i++) begin
      rx = (i < 4) ? 1'b0 : 1'b1;
      tick(1);
      if (busy) saw_busy = 1;
    end
    n_vec++; if (saw_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_seen got=%b exp=1", saw_busy); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid got=%b exp=0", rx_valid); end
    n_vec++; if (fe_pulses !== p0) begin n_err++; $display("FAIL glitch_ferr got=%0d exp=%0d", fe_pulses, p0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent [3];
    logic [7:0] got [$];
    int p0;
    sent[0] = 8'h00;
    sent[1] = 8'hFF;
    sent[2] = 8'h3C;
    p0 = fe_pulses;
    fork
      for (int i = 0; i < 3; i++) send_frame(sent[i], 1'b1);
      begin
        for (int c = 0; c < 3 * 10 * BIT_CLKS + 40; c++) begin
          tick(1);
          if (rx_valid && rx_ack == 1'b0) begin
            got.push_back(data_out);
            pulse_ack();
          end
        end
      end
    join
    n_vec++; if (got.size() !== 3) begin n_err++; $display("FAIL b2b_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        n_vec++; if (got[i] !== sent[i]) begin n_err++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got[i], sent[i]); end
      end
    end
    n_vec++; if (fe_pulses !== p0) begin n_err++; $display("FAIL b2b_ferr got=%0d exp=%0d", fe_pulses, p0); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_ovr got=%b exp=0", overrun); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    tick(2);
    n_vec++; if (data_out !== 8'h11) begin n_err++; $display("FAIL ovr_first got=%h exp=11", data_out); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early got=%b exp=0", overrun); end
    send_frame(8'h22, 1'b1);
    tick(2);
    n_vec++; if (data_out !== 8'h11) begin n_err++; $display("FAIL ovr_keep got=%h exp=11", data_out); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
    pulse_ack();
    tick(3);
    send_frame(8'h33, 1'b1);
    tick(2);
    n_vec++; if (data_out !== 8'h33) begin n_err++; $display("FAIL ovr_next got=%h exp=33", data_out); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    pulse_ack();
    tick(3);
  endtask

  task automatic test_reset_mid_frame();
    fork
      send_frame(8'h96, 1'b1);
      begin
        tick(5 * BIT_CLKS + 8);
        rst = 1'b1;
        #2;
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rstmid_data got=%h exp=00", data_out); end
        n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%b exp=0", rx_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rstmid_ovr got=%b exp=0", overrun); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rstmid_ferr got=%b exp=0", frame_err); end
        abort_tx = 1'b1;
        tick(4);
        rst = 1'b0;
        abort_tx = 1'b0;
      end
    join
    tick(3 * BIT_CLKS);
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_nopartial got=%b exp=0", rx_valid); end
    send_frame(8'h69, 1'b1);
    tick(2);
    n_vec++; if (data_out !== 8'h69) begin n_err++; $display("FAIL rstmid_byte got=%h exp=69", data_out); end
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_valid2 got=%b exp=1", rx_valid); end
  endtask

  // Frame-level model: a good frame is presented if nothing is held,
  // otherwise it is dropped and overrun sticks; a bad stop bit only pulses.
  task automatic test_random();
    logic [7:0] m_data;
    bit m_valid;
    bit m_ovr;
    int m_fe;
    logic [7:0] b;
    bit bad;
    pulse_ack();
    tick(2);
    m_data = 8'h69;
    m_valid = 0;
    m_ovr = 0;
    m_fe = fe_pulses;
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, !bad);
      tick(2);
      if (bad) m_fe++;
      else if (m_valid) m_ovr = 1;
      else begin
        m_data = b;
        m_valid = 1;
      end
      n_vec++; if (data_out !== m_data) begin n_err++; $display("FAIL rand%0d_data got=%h exp=%h", k, data_out, m_data); end
      n_vec++; if (rx_valid !== m_valid) begin n_err++; $display("FAIL rand%0d_valid got=%b exp=%b", k, rx_valid, m_valid); end
      n_vec++; if (overrun !== m_ovr) begin n_err++; $display("FAIL rand%0d_ovr got=%b exp=%b", k, overrun, m_ovr); end
      n_vec++; if (fe_pulses !== m_fe || fe_cycles < 0) begin n_err++; $display("FAIL rand%0d_ferr got=%0d exp=%0d", k, fe_pulses, m_fe); end
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        m_valid = 0;
        n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rand%0d_ack got=%b exp=0", k, rx_valid); end
      end
      tick(bad ? 2 * BIT_CLKS : $urandom_range(0, 20));
    end
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx_ack = 1'b0;
    test_reset();
    test_basic();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the UART link; directly downstream of the transmitter and consumes its serial line.
- Frame format: 8N1. One low start bit, 8 data bits LSB first, one high stop bit; idle line is high.
- Recovers each byte and presents it on a valid/ack handshake to the host logic.
- Reports framing errors and overruns.

Parameters:
- BAUD_DIV, 10416, bit period minus one in clk cycles (bit period = BAUD_DIV+1 clocks); must match the transmitter's value.
- HALF_DIV, BAUD_DIV/2, counter value at which the start bit is checked (mid-bit alignment).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx  input  1  serial line, asynchronous to clk
- rx_ack  input  1  host consumes the held byte; honoured only while rx_valid=1
- data_out  output  8  last good received byte
- rx_valid  output  1  data_out holds an unconsumed byte
- busy  output  1  high whenever the FSM is not IDLE
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low
- overrun  output  1  sticky; set when a good byte completes while rx_valid=1

Behaviour:
- Input synchronisation
  - rx passes through a 2-flop synchroniser (rx_s); all logic uses rx_s only.
  - Synchroniser flops reset to 1.
- Reset values
  - data_out=0, rx_valid=0, busy=0, frame_err=0, overrun=0.
  - FSM=IDLE, baud counter=0, bit index=0, shift register=0.
- Reset mid-frame aborts the frame immediately; no partial byte is ever presented.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: cnt increments each clock. When cnt==HALF_DIV:
    - rx_s==0: go to DATA, cnt=0, bit_idx=0.
    - rx_s==1: treat as a glitch and return to IDLE; no flags change.
  - DATA: when cnt==BAUD_DIV, sample rx_s into the shift register MSB and shift right (LSB-first assembly), cnt=0, bit_idx+1. After the 8th sample (bit_idx==7), go to STOP. Otherwise cnt+1.
  - STOP: when cnt==BAUD_DIV, sample rx_s, then return to IDLE.
    - rx_s==1 and rx_valid==0: data_out<=shift, rx_valid<=1.
    - rx_s==1 and rx_valid==1: data_out and rx_valid are unchanged (new byte dropped), overrun<=1.
    - rx_s==0: frame_err pulses for 1 cycle; data_out and rx_valid are unchanged.
- Counter widths
  - cnt is 16 bits; BAUD_DIV must be ≤ 65535.
  - bit_idx is 3 bits.
- Handshake
  - rx_valid clears on the cycle after rx_ack is sampled high.
  - rx_ack with rx_valid=0 is ignored.
  - Simultaneous rx_ack and good-byte completion in the same cycle: the new byte loads, rx_valid stays 1, no overrun.
- overrun clears only on rst.
- Back-to-back frames: IDLE re-arms on the first cycle after STOP. A start edge arriving immediately after the stop-bit sample is accepted.
- Latency: rx_valid rises between 9.5×(BAUD_DIV+1) and 9.5×(BAUD_DIV+1)+4 clocks after the rx falling edge at the pin.
- A line held low permanently (break) gives: frame_err pulse, return to IDLE, then immediate restart. This repeats once per frame time; this behaviour is required.

Test Plan:
- Basic byte: BAUD_DIV=15; drive 0xA5 8N1 on rx, bit period 16 clocks.
  - rx_valid=1 and data_out=0xA5 within the latency window; frame_err stays 0.
  - Assert rx_ack for 1 cycle → rx_valid=0 next cycle.
- Loopback: connect the transmitter tx to rx with matching BAUD_DIV=15; send 0x00, 0xFF, 0x3C back to back, acking each → received sequence 0x00, 0xFF, 0x3C, no errors.
- Framing error: send 0x55 with the stop bit driven low → frame_err pulses exactly 1 cycle; rx_valid stays 0; data_out keeps its previous value.
- Start glitch: pulse rx low for 4 clocks (< HALF_DIV=7), then high → FSM returns to IDLE, busy falls; no rx_valid, no frame_err.
- Overrun: receive 0x11 without ack, then 0x22 → data_out stays 0x11 and overrun=1. Ack then send 0x33 → data_out=0x33; overrun remains 1.
- Reset mid-frame: assert rst during DATA bit 4 of 0x96, release, then send 0x69 → only 0x69 is presented; all outputs read reset values during rst.
